fib_job_sequencer: RTL and testbench

Clocked front-end for the req/fin four-phase Fibonacci compute core. It accepts N values over a valid/ready stream, resolves N<3 locally, and runs one four-phase transaction per job on the core for N>=3. It synchronises the core's asynchronous fin, captures the result, and returns {N, result, err} through an output FIFO. It is the bridge between the synchronous system and the clockless math stage.

---
 rtl/fib_job_sequencer_if.sv | 29 ++
 rtl/fib_job_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_fib_job_sequencer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fib_job_sequencer_if.sv
// Bundles the job stream, the result stream and the four-phase core handshake
// of fib_job_sequencer; slave is the sequencer side, master is the system/core side.
interface fib_job_sequencer_if #(
    parameter int Width = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [Width-1:0] in_n;
    logic             out_valid;
    logic             out_ready;
    logic [Width-1:0] out_n;
    logic [Width-1:0] out_result;
    logic             out_err;
    logic             core_req;
    logic [Width-1:0] core_N;
    logic             core_fin;
    logic [Width-1:0] core_result;
    logic             busy;

    modport master (
        output in_valid, in_n, out_ready, core_fin, core_result,
        input  in_ready, out_valid, out_n, out_result, out_err, core_req, core_N, busy
    );

    modport slave (
        input  in_valid, in_n, out_ready, core_fin, core_result,
        output in_ready, out_valid, out_n, out_result, out_err, core_req, core_N, busy
    );
endinterface

// File: rtl/fib_job_sequencer.sv
// Clocked front-end for the four-phase Fibonacci core: accepts N, resolves N<3
// locally, runs req/fin transactions otherwise and returns results in order through a FIFO.
module fib_job_sequencer #(
    parameter int Width         = 32,
    parameter int Depth         = 4,
    parameter int SyncStages    = 2,
    parameter int TimeoutCycles = 4096
) (
    input  logic               clk,
    input  logic               rst,
    fib_job_sequencer_if.slave bus
);
    localparam int               PtrW        = $clog2(Depth);
    localparam logic [PtrW:0]    DepthC      = (PtrW + 1)'(Depth);
    localparam logic [Width-1:0] NThree      = Width'(3);
    localparam logic [Width-1:0] ResOne      = Width'(1);
    localparam logic [31:0]      TimeoutLast = (TimeoutCycles == 0) ? 32'd0 : 32'(TimeoutCycles - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOCAL  = 3'd1,
        REQ_HI = 3'd2,
        REQ_LO = 3'd3,
        PUSH   = 3'd4
    } state_t;

    state_t               state_r;
    state_t               nextState_s;
    logic [SyncStages-1:0] finSync_r;
    logic                 finS_s;
    logic                 coreReq_r;
    logic [Width-1:0]     coreN_r;
    logic [Width-1:0]     localN_r;
    logic [31:0]          waitCnt_r;
    logic [Width-1:0]     resQ_r;
    logic                 errQ_r;

    logic [Width-1:0]     nMem_r   [Depth];
    logic [Width-1:0]     resMem_r [Depth];
    logic                 errMem_r [Depth];
    logic [PtrW-1:0]      wrPtr_r;
    logic [PtrW-1:0]      rdPtr_r;
    logic [PtrW:0]        count_r;

    logic                 inReady_s;
    logic                 accept_s;
    logic                 pop_s;
    logic                 timeout_s;
    logic                 latchLocal_s;
    logic                 startCore_s;
    logic                 capture_s;
    logic                 timeoutHit_s;
    logic                 countWait_s;
    logic                 clearErr_s;
    logic                 push_s;
    logic [Width-1:0]     pushN_s;
    logic [Width-1:0]     pushRes_s;
    logic                 pushErr_s;

    assign finS_s = finSync_r[SyncStages-1];
    // A fin still high from an aborted transaction must drain before a new job may start.
    assign inReady_s = !rst && (state_r == IDLE) && (count_r < DepthC) && !finS_s;
    assign accept_s  = bus.in_valid && inReady_s;
    assign pop_s     = bus.out_ready && (count_r != '0);
    assign timeout_s = (TimeoutCycles != 0) && (waitCnt_r == TimeoutLast);

    assign bus.in_ready   = inReady_s;
    assign bus.out_valid  = (count_r != '0);
    assign bus.out_n      = nMem_r[rdPtr_r];
    assign bus.out_result = resMem_r[rdPtr_r];
    assign bus.out_err    = errMem_r[rdPtr_r];
    assign bus.core_req   = coreReq_r;
    assign bus.core_N     = coreN_r;
    assign bus.busy       = (state_r != IDLE);

    // Synchroniser for the clockless core's fin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            finSync_r <= '0;
        end else begin
            finSync_r <= {finSync_r[SyncStages-2:0], bus.core_fin};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // FSM next state and datapath strobes.
    always_comb begin
        nextState_s  = state_r;
        latchLocal_s = 1'b0;
        startCore_s  = 1'b0;
        capture_s    = 1'b0;
        timeoutHit_s = 1'b0;
        countWait_s  = 1'b0;
        clearErr_s   = 1'b0;
        push_s       = 1'b0;
        pushN_s      = '0;
        pushRes_s    = '0;
        pushErr_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (bus.in_n < NThree) begin
                        latchLocal_s = 1'b1;
                        nextState_s  = LOCAL;
                    end else begin
                        startCore_s = 1'b1;
                        nextState_s = REQ_HI;
                    end
                end else begin
                    nextState_s = IDLE;
                end
            end
            LOCAL: begin
                push_s      = 1'b1;
                pushN_s     = localN_r;
                pushRes_s   = (localN_r == '0) ? '0 : ResOne;
                nextState_s = IDLE;
            end
            REQ_HI: begin
                if (finS_s) begin
                    capture_s   = 1'b1;
                    nextState_s = REQ_LO;
                end else if (timeout_s) begin
                    timeoutHit_s = 1'b1;
                    nextState_s  = REQ_LO;
                end else begin
                    countWait_s = 1'b1;
                    nextState_s = REQ_HI;
                end
            end
            REQ_LO: begin
                if (!finS_s) begin
                    nextState_s = PUSH;
                end else begin
                    nextState_s = REQ_LO;
                end
            end
            PUSH: begin
                push_s      = 1'b1;
                pushN_s     = coreN_r;
                pushRes_s   = resQ_r;
                pushErr_s   = errQ_r;
                clearErr_s  = 1'b1;
                nextState_s = IDLE;
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // Job registers, core request and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coreReq_r <= 1'b0;
            coreN_r   <= '0;
            localN_r  <= '0;
            waitCnt_r <= 32'd0;
            resQ_r    <= '0;
            errQ_r    <= 1'b0;
        end else begin
            if (latchLocal_s) begin
                localN_r <= bus.in_n;
            end
            if (startCore_s) begin
                coreN_r   <= bus.in_n;
                coreReq_r <= 1'b1;
                waitCnt_r <= 32'd0;
            end else if (capture_s || timeoutHit_s) begin
                coreReq_r <= 1'b0;
            end else if (countWait_s) begin
                waitCnt_r <= waitCnt_r + 32'd1;
            end
            // core_result is bundled data: only trusted on the first synchronised fin.
            if (capture_s) begin
                resQ_r <= bus.core_result;
                errQ_r <= 1'b0;
            end else if (timeoutHit_s) begin
                resQ_r <= '0;
                errQ_r <= 1'b1;
            end else if (clearErr_s) begin
                errQ_r <= 1'b0;
            end
        end
    end

    // Output FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                nMem_r[i]   <= '0;
                resMem_r[i] <= '0;
                errMem_r[i] <= 1'b0;
            end
            wrPtr_r <= '0;
            rdPtr_r <= '0;
            count_r <= '0;
        end else begin
            if (push_s) begin
                nMem_r[wrPtr_r]   <= pushN_s;
                resMem_r[wrPtr_r] <= pushRes_s;
                errMem_r[wrPtr_r] <= pushErr_s;
                wrPtr_r           <= wrPtr_r + PtrW'(1);
            end
            if (pop_s) begin
                rdPtr_r <= rdPtr_r + PtrW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PtrW + 1)'(1);
                2'b01:   count_r <= count_r - (PtrW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    fib_job_sequencer_checker #(
        .Width (Width),
        .PtrW  (PtrW),
        .Depth (Depth)
    ) u_checker (
        .clk     (clk),
        .rst     (rst),
        .inIdle  (state_r == IDLE),
        .inReqHi (state_r == REQ_HI),
        .coreReq (coreReq_r),
        .coreN   (coreN_r),
        .push    (push_s),
        .pop     (pop_s),
        .count   (count_r)
    );
endmodule

// Structural invariants of the sequencer: FIFO bounds and the core handshake.
module fib_job_sequencer_checker #(
    parameter int Width = 32,
    parameter int PtrW  = 2,
    parameter int Depth = 4
) (
    input logic             clk,
    input logic             rst,
    input logic             inIdle,
    input logic             inReqHi,
    input logic             coreReq,
    input logic [Width-1:0] coreN,
    input logic             push,
    input logic             pop,
    input logic [PtrW:0]    count
);
    localparam logic [PtrW:0] DepthC = (PtrW + 1)'(Depth);

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= DepthC);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !pop && (count == DepthC)));
    a_req_in_req_hi: assert property (@(posedge clk) disable iff (rst) coreReq == inReqHi);
    a_core_n_held: assert property (@(posedge clk) disable iff (rst) !inIdle |=> $stable(coreN));
endmodule

// File: tb/tb_fib_job_sequencer.sv
// Directed self-checking bench for fib_job_sequencer with a behavioural four-phase core model.
module tb_fib_job_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nCompared   = 0;
    int   nMismatched = 0;
    int   finDelay    = 7;
    int   finLowDelay = 2;
    bit   neverFin    = 1'b0;
    int   reqRises    = 0;

    fib_job_sequencer_if #(.Width(32)) bus ();
    fib_job_sequencer_if #(.Width(8))  bus8 ();

    fib_job_sequencer #(.Width(32), .Depth(4), .SyncStages(2), .TimeoutCycles(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fib_job_sequencer #(.Width(8), .Depth(4), .SyncStages(2), .TimeoutCycles(16)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fibModel(input logic [31:0] n);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] t;
        a = 32'd0;
        b = 32'd1;
        for (int i = 0; i < int'(n); i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Core model for the 32-bit instance; result is garbage except while fin is high.
    initial begin
        logic [31:0] modelN;
        bus.core_fin    = 1'b0;
        bus.core_result = 32'hDEAD_BEEF;
        forever begin
            @(posedge bus.core_req);
            reqRises++;
            modelN = bus.core_N;
            bus.core_result = 32'hDEAD_BEEF;
            if (!neverFin) begin
                repeat (finDelay) @(posedge clk);
                #2;
                bus.core_result = fibModel(modelN);
                bus.core_fin    = 1'b1;
            end
            wait (bus.core_req == 1'b0);
            repeat (finLowDelay) @(posedge clk);
            #2;
            bus.core_fin    = 1'b0;
            bus.core_result = 32'hDEAD_BEEF;
        end
    end

    // Core model for the 8-bit instance.
    initial begin
        logic [31:0] full;
        bus8.core_fin    = 1'b0;
        bus8.core_result = 8'hA5;
        forever begin
            @(posedge bus8.core_req);
            full = fibModel({24'd0, bus8.core_N});
            repeat (4) @(posedge clk);
            #2;
            bus8.core_result = full[7:0];
            bus8.core_fin    = 1'b1;
            wait (bus8.core_req == 1'b0);
            repeat (2) @(posedge clk);
            #2;
            bus8.core_fin    = 1'b0;
            bus8.core_result = 8'hA5;
        end
    end

    task automatic sendJob(input logic [31:0] n);
        int cyc = 0;
        bus.in_n     = n;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        nCompared++;
        if (bus.in_ready !== 1'b1) begin
            nMismatched++;
            $display("FAIL accept_timeout n=%0d in_ready=%b required 1", n, bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic popEntry(output logic [31:0] n, output logic [31:0] r, output logic e);
        int cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        nCompared++;
        if (bus.out_valid !== 1'b1) begin
            nMismatched++;
            $display("FAIL pop_timeout out_valid=%b required 1", bus.out_valid);
        end
        n = bus.out_n;
        r = bus.out_result;
        e = bus.out_err;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nCompared++;
        if ({bus.in_ready, bus.out_valid, bus.core_req, bus.busy, bus.out_err} !== 5'b00000) begin
            nMismatched++;
            $display("FAIL reset_flags got=%b required 00000",
                     {bus.in_ready, bus.out_valid, bus.core_req, bus.busy, bus.out_err});
        end
        nCompared++;
        if ((bus.out_n | bus.out_result | bus.core_N) !== 32'd0) begin
            nMismatched++;
            $display("FAIL reset_data out_n=%0d out_result=%0d core_N=%0d required 0",
                     bus.out_n, bus.out_result, bus.core_N);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        nCompared++;
        if (bus.in_ready !== 1'b1) begin
            nMismatched++;
            $display("FAIL ready_after_reset got=%b required 1", bus.in_ready);
        end
    endtask

    task automatic test_core_job();
        logic [31:0] n;
        logic [31:0] r;
        logic        e;
        int          cyc = 0;
        int          readyLeaks = 0;
        finDelay    = 7;
        finLowDelay = 2;
        sendJob(32'd10);
        nCompared++;
        if ({bus.core_req, bus.busy} !== 2'b11) begin
            nMismatched++;
            $display("FAIL req_latency core_req,busy=%b required 11", {bus.core_req, bus.busy});
        end
        while (bus.out_valid !== 1'b1 && cyc < 100) begin
            if (bus.in_ready === 1'b1) readyLeaks++;
            @(posedge clk); #1;
            cyc++;
        end
        nCompared++;
        if (readyLeaks != 0) begin
            nMismatched++;
            $display("FAIL ready_while_busy cycles=%0d required 0", readyLeaks);
        end
        popEntry(n, r, e);
        nCompared++;
        if ({n, r, e} !== {32'd10, 32'd55, 1'b0}) begin
            nMismatched++;
            $display("FAIL fib10 n=%0d result=%0d err=%b required 10/55/0", n, r, e);
        end
        nCompared++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            nMismatched++;
            $display("FAIL after_fib10 in_ready,out_valid=%b required 10", {bus.in_ready, bus.out_valid});
        end
    endtask

    task automatic test_local();
        logic [31:0] n;
        logic [31:0] r;
        logic        e;
        logic [31:0] expRes [3];
        int          rises0;
        expRes[0] = 32'd0;
        expRes[1] = 32'd1;
        expRes[2] = 32'd1;
        rises0 = reqRises;
        sendJob(32'd0);
        nCompared++;
        if (bus.out_valid !== 1'b0) begin
            nMismatched++;
            $display("FAIL local_push_early out_valid=%b required 0", bus.out_valid);
        end
        @(posedge clk); #1;
        nCompared++;
        if (bus.out_valid !== 1'b1) begin
            nMismatched++;
            $display("FAIL local_push_latency out_valid=%b required 1", bus.out_valid);
        end
        sendJob(32'd1);
        sendJob(32'd2);
        @(posedge clk); #1;
        nCompared++;
        if (reqRises != rises0) begin
            nMismatched++;
            $display("FAIL local_no_core req_rises=%0d required %0d", reqRises, rises0);
        end
        for (int i = 0; i < 3; i++) begin
            popEntry(n, r, e);
            nCompared++;
            if ({n, r, e} !== {32'(i), expRes[i], 1'b0}) begin
                nMismatched++;
                $display("FAIL local_result%0d n=%0d result=%0d err=%b required %0d/%0d/0",
                         i, n, r, e, i, expRes[i]);
            end
        end
    endtask

    task automatic test_fifo_full();
        logic [31:0] n;
        logic [31:0] r;
        logic        e;
        logic [31:0] expN   [4];
        logic [31:0] expRes [4];
        int          cyc = 0;
        expN[0] = 32'd20; expRes[0] = 32'd6765;
        expN[1] = 32'd2;  expRes[1] = 32'd1;
        expN[2] = 32'd7;  expRes[2] = 32'd13;
        expN[3] = 32'd1;  expRes[3] = 32'd1;
        sendJob(32'd3);
        sendJob(32'd20);
        sendJob(32'd2);
        sendJob(32'd7);
        while (bus.busy !== 1'b0 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_n     = 32'd1;
        bus.in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        nCompared++;
        if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b001) begin
            nMismatched++;
            $display("FAIL full_stall in_ready,busy,out_valid=%b required 001",
                     {bus.in_ready, bus.busy, bus.out_valid});
        end
        popEntry(n, r, e);
        nCompared++;
        if ({n, r, e} !== {32'd3, 32'd2, 1'b0}) begin
            nMismatched++;
            $display("FAIL fifo_head n=%0d result=%0d err=%b required 3/2/0", n, r, e);
        end
        nCompared++;
        if (bus.in_ready !== 1'b1) begin
            nMismatched++;
            $display("FAIL ready_after_pop got=%b required 1", bus.in_ready);
        end
        sendJob(32'd1);
        for (int i = 0; i < 4; i++) begin
            popEntry(n, r, e);
            nCompared++;
            if ({n, r, e} !== {expN[i], expRes[i], 1'b0}) begin
                nMismatched++;
                $display("FAIL fifo_order%0d n=%0d result=%0d err=%b required %0d/%0d/0",
                         i, n, r, e, expN[i], expRes[i]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] n;
        logic [31:0] r;
        logic        e;
        int          hi = 0;
        neverFin = 1'b1;
        sendJob(32'd5);
        while (bus.core_req === 1'b1 && hi < 100) begin
            @(posedge clk); #1;
            hi++;
        end
        nCompared++;
        if (hi != 16) begin
            nMismatched++;
            $display("FAIL timeout_req_width cycles=%0d required 16", hi);
        end
        neverFin = 1'b0;
        popEntry(n, r, e);
        nCompared++;
        if ({n, r, e} !== {32'd5, 32'd0, 1'b1}) begin
            nMismatched++;
            $display("FAIL timeout_entry n=%0d result=%0d err=%b required 5/0/1", n, r, e);
        end
        sendJob(32'd4);
        popEntry(n, r, e);
        nCompared++;
        if ({n, r, e} !== {32'd4, 32'd3, 1'b0}) begin
            nMismatched++;
            $display("FAIL after_timeout n=%0d result=%0d err=%b required 4/3/0", n, r, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] n;
        logic [31:0] r;
        logic        e;
        int          cyc = 0;
        int          readyLeaks = 0;
        finDelay    = 3;
        finLowDelay = 10;
        sendJob(32'd1);
        @(posedge clk); #1;
        sendJob(32'd7);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        nCompared++;
        if ({bus.core_req, bus.out_valid, bus.busy} !== 3'b000) begin
            nMismatched++;
            $display("FAIL rst_mid_clear core_req,out_valid,busy=%b required 000",
                     {bus.core_req, bus.out_valid, bus.busy});
        end
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        while (bus.core_fin === 1'b1 && cyc < 50) begin
            if (bus.in_ready === 1'b1) readyLeaks++;
            @(posedge clk); #1;
            cyc++;
        end
        // fin fell during the previous cycle: one synchroniser stage still holds it high.
        if (bus.in_ready === 1'b1) readyLeaks++;
        nCompared++;
        if (readyLeaks != 0 || cyc == 0 || cyc >= 50) begin
            nMismatched++;
            $display("FAIL rst_fin_block ready_cycles=%0d fin_cycles=%0d required 0 and 1..49",
                     readyLeaks, cyc);
        end
        @(posedge clk); #1;
        nCompared++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            nMismatched++;
            $display("FAIL ready_after_fin_low in_ready,out_valid=%b required 10",
                     {bus.in_ready, bus.out_valid});
        end
        finDelay    = 7;
        finLowDelay = 2;
        sendJob(32'd6);
        popEntry(n, r, e);
        nCompared++;
        if ({n, r, e} !== {32'd6, 32'd8, 1'b0}) begin
            nMismatched++;
            $display("FAIL after_rst_mid n=%0d result=%0d err=%b required 6/8/0", n, r, e);
        end
    endtask

    task automatic test_width8();
        int cyc = 0;
        bus8.in_n     = 8'd14;
        bus8.in_valid = 1'b1;
        while (bus8.in_ready !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        cyc = 0;
        while (bus8.out_valid !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        nCompared++;
        if ({bus8.out_valid, bus8.out_n, bus8.out_result, bus8.out_err} !== {1'b1, 8'd14, 8'd121, 1'b0}) begin
            nMismatched++;
            $display("FAIL width8_wrap valid=%b n=%0d result=%0d err=%b required 1/14/121/0",
                     bus8.out_valid, bus8.out_n, bus8.out_result, bus8.out_err);
        end
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_n       = 32'd0;
        bus.out_ready  = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.in_n      = 8'd0;
        bus8.out_ready = 1'b0;
        test_reset();
        test_core_job();
        test_local();
        test_fifo_full();
        test_timeout();
        test_reset_mid();
        test_width8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
